// File: rtl/fsm_dispatcher_pkg.sv
// Shared control-unit definitions: per-channel control bundle, dispatcher states
// and index-width helper.
package fsm_dispatcher_pkg;

    typedef struct packed {
        logic [1:0]  sel_rd;
        logic [18:0] flags;
    } ctrl_bundle_t;

    localparam int unsigned CTRL_W = $bits(ctrl_bundle_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } disp_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fsm_dispatcher_onehot_to_index.sv
// Converts an N-bit request vector to a binary index; valid only when exactly one bit is set.
module onehot_to_index
    import fsm_dispatcher_pkg::*;
#(
    parameter  int unsigned N    = 3,
    localparam int unsigned IDXW = idx_width(N)
) (
    input  logic [N-1:0]    vec_i,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o
);

    // OR of set-bit positions; meaningful only when valid_o is high
    always_comb begin
        idx_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (vec_i[k]) begin
                idx_o = idx_o | IDXW'(k);
            end
        end
    end

    assign valid_o = (vec_i != '0) && ((vec_i & (vec_i - N'(1))) == '0);

endmodule

// File: rtl/fsm_dispatcher.sv
// Instruction-class dispatcher: accepts a one-hot start, grants one sub-FSM, muxes its
// control bundle out until completion, and guards the run with a watchdog.
module fsm_dispatcher
    import fsm_dispatcher_pkg::*;
#(
    parameter  int unsigned N       = 3,
    parameter  int unsigned CW      = CTRL_W,
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned IDXW    = idx_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    start,
    input  logic            clear,
    input  logic [N*CW-1:0] ctrl_in,
    input  logic [N-1:0]    done_in,
    output logic [N-1:0]    grant,
    output logic [CW-1:0]   ctrl_out,
    output logic            done,
    output logic            busy,
    output logic [IDXW-1:0] owner,
    output logic            illegal,
    output logic            overrun,
    output logic            timeout
);

    localparam int unsigned    WDW     = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    disp_state_e     state_q, state_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic            illegal_q, illegal_d;
    logic            overrun_q, overrun_d;

    logic [IDXW-1:0] start_idx;
    logic            start_valid;
    logic            start_any;
    logic            in_run;
    logic [CW-1:0]   owner_ctrl;
    logic            owner_done;

    onehot_to_index #(.N(N)) u_start_dec (
        .vec_i   (start),
        .idx_o   (start_idx),
        .valid_o (start_valid)
    );

    assign start_any = |start;
    assign in_run    = (state_q == ST_RUN);

    // Owner-selected bundle and completion; other channels are ignored
    always_comb begin
        owner_ctrl = '0;
        owner_done = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (owner_q == IDXW'(k)) begin
                owner_ctrl = ctrl_in[k*CW +: CW];
                owner_done = done_in[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant_d   = '0;
        wd_d      = wd_q;
        illegal_d = illegal_q;
        overrun_d = overrun_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    state_d = ST_RUN;
                    owner_d = start_idx;
                    grant_d = start;
                    wd_d    = '0;
                end else if (start_any) begin
                    illegal_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (start_any) begin
                    overrun_d = 1'b1;
                end
                // Completion beats the watchdog when both land in the same cycle
                if (owner_done) begin
                    state_d = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            ST_ERROR: begin
                if (start_any) begin
                    overrun_d = 1'b1;
                end
                if (clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear) begin
            illegal_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            grant_q   <= '0;
            wd_q      <= '0;
            illegal_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            wd_q      <= wd_d;
            illegal_q <= illegal_d;
            overrun_q <= overrun_d;
        end
    end

    assign grant    = grant_q;
    assign owner    = owner_q;
    assign illegal  = illegal_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != ST_IDLE);
    assign timeout  = (state_q == ST_ERROR);
    assign ctrl_out = in_run ? owner_ctrl : '0;
    assign done     = in_run & owner_done;

endmodule
